// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: SQI quad-mode serial SRAM responder (READ 0x03 / WRITE 0x02, auto-increment).
// Define IDLI_SQI_MEM_PAGE_EN to make auto-increment wrap within a 32-byte page.
module idli_sqi_mem_m #(
   parameter int MEM_BYTES = 256,
   parameter int ADDR_W    = 16
) (
   input  logic       i_sqi_gck,
   input  logic       i_sqi_rst,
   input  logic       i_sqi_sck,
   input  logic       i_sqi_cs,
   input  logic [3:0] i_sqi_sio,
   output logic [3:0] o_sqi_sio,
   output logic       o_sqi_sio_oe
);
   localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [1:0] ADDR_LAST = 2'(ADDR_W / 4 - 1);
   typedef enum logic [2:0] {IDLE, INSTR, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;
   state_t state_q, state_d;
   logic sck_prev_q, rise, fall, rd_q, rd_d, oe_d, wr_en;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] hi_q, hi_d, sio_d;
   logic [IDX_W-1:0] addr_q, addr_d, addr_inc;
   logic [7:0] mem [MEM_BYTES];
   assign rise = i_sqi_sck & ~sck_prev_q;
   assign fall = ~i_sqi_sck & sck_prev_q;
`ifdef IDLI_SQI_MEM_PAGE_EN
   assign addr_inc = (addr_q & ~IDX_W'(31)) | ((addr_q + IDX_W'(1)) & IDX_W'(31));
`else
   assign addr_inc = addr_q + IDX_W'(1);
`endif
   always_ff @(posedge i_sqi_gck) begin
      sck_prev_q <= i_sqi_rst ? 1'b0 : i_sqi_sck;
      if (i_sqi_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         hi_q         <= '0;
         rd_q         <= 1'b0;
         addr_q       <= '0;
         o_sqi_sio    <= '0;
         o_sqi_sio_oe <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         rd_q         <= rd_d;
         addr_q       <= addr_d;
         o_sqi_sio    <= sio_d;
         o_sqi_sio_oe <= oe_d;
      end
   end
   always_ff @(posedge i_sqi_gck)
      if (wr_en) mem[addr_q] <= {hi_q, i_sqi_sio};
   always_comb begin
      state_d = state_q;
      if (i_sqi_cs) state_d = IDLE;
      else if (rise)
         case (state_q)
            IDLE:    state_d = INSTR;
            INSTR:   state_d = ({hi_q, i_sqi_sio[3:1]} == 7'h01) ? ADDR : IGNORE;
            ADDR:    state_d = (cnt_q == ADDR_LAST) ? (rd_q ? DUMMY : WR_DATA) : ADDR;
            DUMMY:   state_d = cnt_q[0] ? RD_DATA : DUMMY;
            default: state_d = state_q;
         endcase
   end
   // hi_q holds the instruction high nibble, then the pending write high nibble
   always_comb begin
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      rd_d   = rd_q;
      addr_d = addr_q;
      sio_d  = o_sqi_sio;
      oe_d   = o_sqi_sio_oe;
      wr_en  = 1'b0;
      if (i_sqi_cs) begin
         cnt_d = '0;
         oe_d  = 1'b0;
      end else if (rise) begin
         case (state_q)
            IDLE:  hi_d = i_sqi_sio;
            INSTR: begin
               rd_d  = i_sqi_sio[0];
               cnt_d = '0;
            end
            ADDR: begin
               addr_d = IDX_W'({addr_q, i_sqi_sio});
               cnt_d  = cnt_q + 2'd1;
            end
            DUMMY:   cnt_d = {1'b0, ~cnt_q[0]};
            RD_DATA: begin
               cnt_d  = {1'b0, ~cnt_q[0]};
               addr_d = cnt_q[0] ? addr_inc : addr_q;
            end
            WR_DATA: begin
               cnt_d  = {1'b0, ~cnt_q[0]};
               hi_d   = cnt_q[0] ? hi_q : i_sqi_sio;
               addr_d = cnt_q[0] ? addr_inc : addr_q;
               wr_en  = cnt_q[0] & ~i_sqi_rst;
            end
            default: ;
         endcase
      end else if (fall && state_q == RD_DATA) begin
         sio_d = cnt_q[0] ? mem[addr_q][3:0] : mem[addr_q][7:4];
         oe_d  = 1'b1;
      end
   end
endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// tb_idli_sqi_mem_m: vector table, corner-case sequences and random traffic checked
// against a flat byte-array model of the SQI memory.
module tb_idli_sqi_mem_m;
   logic gck = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1;
   logic [3:0] sio_in = 4'h0;
   logic [3:0] sio_out;
   logic oe, roe, bad;
   logic [7:0] model [256];
   logic [7:0] wbuf [32];
   logic [7:0] rbuf [32];
   logic [3:0] ign [10];
   logic [7:0] ma;
   logic [15:0] ra;
   int tests = 0, fails = 0, n;
   typedef struct { bit w; logic [15:0] a; logic [7:0] d0; logic [7:0] d1; } vec_t;
   vec_t vecs [7];

   idli_sqi_mem_m dut (
      .i_sqi_gck(gck), .i_sqi_rst(rst), .i_sqi_sck(sck), .i_sqi_cs(cs),
      .i_sqi_sio(sio_in), .o_sqi_sio(sio_out), .o_sqi_sio_oe(oe)
   );

   always #5 gck = ~gck;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] nxt(input logic [7:0] a);
`ifdef IDLI_SQI_MEM_PAGE_EN
      return {a[7:5], a[4:0] + 5'd1};
`else
      return a + 8'd1;
`endif
   endfunction

   task automatic cyc(input logic [3:0] nib);
      sio_in = nib;
      sck = 1'b1;
      @(negedge gck);
      sck = 1'b0;
      @(negedge gck);
   endtask

   task automatic start(input logic [7:0] ins, input logic [15:0] a);
      cs = 1'b0;
      @(negedge gck);
      cyc(ins[7:4]);
      cyc(ins[3:0]);
      for (int i = 3; i >= 0; i--) cyc(a[i*4 +: 4]);
   endtask

   task automatic stop();
      cs = 1'b1;
      @(negedge gck);
      @(negedge gck);
   endtask

   task automatic wr(input logic [15:0] a, input int cnt);
      logic [7:0] m;
      m = a[7:0];
      start(8'h02, a);
      for (int i = 0; i < cnt; i++) begin
         cyc(wbuf[i][7:4]);
         cyc(wbuf[i][3:0]);
         model[m] = wbuf[i];
         m = nxt(m);
      end
      stop();
   endtask

   task automatic rd(input logic [15:0] a, input int cnt);
      start(8'h03, a);
      cyc(4'h0);
      roe = 1'b1;
      for (int i = 0; i < 2 * cnt; i++) begin
         cyc(4'h0);
         roe = roe & oe;
         if (i % 2 == 0) rbuf[i/2][7:4] = sio_out;
         else rbuf[i/2][3:0] = sio_out;
      end
      stop();
   endtask

   initial begin
      vecs[0] = '{1'b1, 16'h0010, 8'hA5, 8'h3C};
      vecs[1] = '{1'b0, 16'h0010, 8'hA5, 8'h3C};
      vecs[2] = '{1'b0, 16'h1210, 8'hA5, 8'h3C};
      vecs[3] = '{1'b1, 16'h00FF, 8'h11, 8'h22};
      vecs[4] = '{1'b0, 16'h00FF, 8'h11, 8'h22};
`ifdef IDLI_SQI_MEM_PAGE_EN
      vecs[5] = '{1'b0, 16'h003F, 8'h65, 8'h7A};
      vecs[6] = '{1'b0, 16'h0000, 8'h5A, 8'h5B};
`else
      vecs[5] = '{1'b0, 16'h003F, 8'h65, 8'h1A};
      vecs[6] = '{1'b0, 16'h0000, 8'h22, 8'h5B};
`endif
      ign = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hE, 4'hE};
      repeat (2) @(negedge gck);
      check("reset sio", sio_out, 0);
      check("reset oe", oe, 0);
      rst = 1'b0;
      @(negedge gck);
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 32; i++) wbuf[i] = 8'(p * 32 + i) ^ 8'h5A;
         wr(16'(p * 32), 32);
      end
      for (int k = 0; k < 7; k++) begin
         if (vecs[k].w) begin
            wbuf[0] = vecs[k].d0;
            wbuf[1] = vecs[k].d1;
            wr(vecs[k].a, 2);
         end else begin
            rd(vecs[k].a, 2);
            check($sformatf("vec%0d byte0", k), rbuf[0], vecs[k].d0);
            check($sformatf("vec%0d byte1", k), rbuf[1], vecs[k].d1);
            check($sformatf("vec%0d oe", k), roe, 1);
         end
      end
      // unknown instruction followed by write-like traffic
      cs = 1'b0;
      @(negedge gck);
      cyc(4'hF);
      cyc(4'hF);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(ign[i]);
         bad = bad | oe;
      end
      stop();
      check("ignore oe", bad, 0);
      rd(16'h0010, 2);
      check("ignore mem0", rbuf[0], model[8'h10]);
      check("ignore mem1", rbuf[1], model[8'h11]);
      // partial byte discarded on CS high
      start(8'h02, 16'h0004);
      cyc(4'h7);
      stop();
      rd(16'h0004, 1);
      check("partial byte", rbuf[0], model[8'h04]);
      // latency and CS abort with simultaneous SCK rise
      start(8'h03, 16'h0010);
      cyc(4'h0);
      sck = 1'b1;
      @(negedge gck);
      check("oe before first fall", oe, 0);
      sck = 1'b0;
      @(negedge gck);
      check("first nibble oe", oe, 1);
      check("first nibble", sio_out, model[8'h10][7:4]);
      cyc(4'h0);
      check("second nibble", sio_out, model[8'h10][3:0]);
      sck = 1'b1;
      cs = 1'b1;
      @(negedge gck);
      check("cs abort oe", oe, 0);
      sck = 1'b0;
      @(negedge gck);
      @(negedge gck);
      check("cs abort oe held", oe, 0);
      rd(16'h0020, 2);
      check("after abort byte0", rbuf[0], model[8'h20]);
      check("after abort byte1", rbuf[1], model[8'h21]);
      // reset in the middle of a read
      start(8'h03, 16'h0030);
      cyc(4'h0);
      cyc(4'h0);
      check("pre-reset oe", oe, 1);
      rst = 1'b1;
      @(negedge gck);
      check("mid reset oe", oe, 0);
      check("mid reset sio", sio_out, 0);
      rst = 1'b0;
      stop();
      rd(16'h0010, 2);
      check("post reset byte0", rbuf[0], model[8'h10]);
      check("post reset byte1", rbuf[1], model[8'h11]);
      // random traffic against the byte-array model
      for (int t = 0; t < 24; t++) begin
         ra = 16'($urandom);
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            wr(ra, n);
         end else begin
            rd(ra, n);
            ma = ra[7:0];
            for (int i = 0; i < n; i++) begin
               check($sformatf("rand%0d byte%0d @%0h", t, i, ma), rbuf[i], model[ma]);
               ma = nxt(ma);
            end
            check($sformatf("rand%0d oe", t), roe, 1);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
